// File: rtl/tiny_mips_pkg.sv
// Shared widths, forwarding-select encodings and pipeline control-bundle types for the
// tiny MIPS control path.
package tiny_mips_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ALUCTRL_W = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic                 regwrite;
    logic                 memtoreg;
    logic                 memwrite;
    logic                 alusrc;
    logic                 regdst;
    logic [ALUCTRL_W-1:0] alucontrol;
    reg_addr_t            rs;
    reg_addr_t            rt;
    reg_addr_t            rd;
  } e_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    logic      memtoreg;
    logic      memwrite;
    reg_addr_t writereg;
  } m_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    logic      memtoreg;
    reg_addr_t writereg;
  } w_ctrl_t;

  // $0 is hardwired, so a write to it is never a hazard or forwarding source.
  function automatic logic reg_hit(reg_addr_t wr, reg_addr_t a, reg_addr_t b);
    return (wr != '0) && ((wr == a) || (wr == b));
  endfunction

  function automatic logic [1:0] fwd_sel(reg_addr_t src, logic regwritem, reg_addr_t writeregm,
                                         logic regwritew, reg_addr_t writeregw);
    if (src == '0) return FWD_RF;
    if (regwritem && (writeregm == src)) return FWD_MEM;
    if (regwritew && (writeregw == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-control bundle in, staged controls, hazard and forwarding controls out.
// master = decode/datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  import tiny_mips_pkg::*;

  logic                 regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd;
  logic [ALUCTRL_W-1:0] alucontrold;
  logic [1:0]           pcsrcd;
  reg_addr_t            rsd, rtd, rdd;

  logic                 regwritee, memtorege, memwritee, alusrce;
  logic [ALUCTRL_W-1:0] alucontrole;
  reg_addr_t            rse, rte, writerege;
  logic                 regwritem, memtoregm, memwritem;
  reg_addr_t            writeregm;
  logic                 regwritew, memtoregw;
  reg_addr_t            writeregw;

  logic                 stallf, stalld, flushd, flushe;
  logic [1:0]           forwardae, forwardbe;
  logic                 forwardad, forwardbd;

  modport master (
    output regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd, alucontrold, pcsrcd,
           rsd, rtd, rdd,
    input  regwritee, memtorege, memwritee, alusrce, alucontrole, rse, rte, writerege,
           regwritem, memtoregm, memwritem, writeregm, regwritew, memtoregw, writeregw,
           stallf, stalld, flushd, flushe, forwardae, forwardbe, forwardad, forwardbd
  );

  modport slave (
    input  regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd, alucontrold, pcsrcd,
           rsd, rtd, rdd,
    output regwritee, memtorege, memwritee, alusrce, alucontrole, rse, rte, writerege,
           regwritem, memtoregm, memwritem, writeregm, regwritew, memtoregw, writeregw,
           stallf, stalld, flushd, flushe, forwardae, forwardbe, forwardad, forwardbd
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline control register: synchronous reset, synchronous clear (bubble insert).
module ctrl_stage_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else                q <= d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Registers decode controls through EX/MEM/WB and derives stall, flush and forwarding selects.
// Optional feature: define BRANCH_FWD_EN to forward MEM results into the decode branch compare.
module pipe_hazard_ctrl
  import tiny_mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus,
    output logic [CNT_W-1:0]  stall_cnt
);

  e_ctrl_t   e_d, e_q;
  m_ctrl_t   m_d, m_q;
  w_ctrl_t   w_d, w_q;
  reg_addr_t writerege;
  logic      lwstall, branchstall, stall;
  logic      fwd_ad, fwd_bd;

  always_comb begin
    e_d            = '0;
    e_d.regwrite   = bus.regwrited;
    e_d.memtoreg   = bus.memtoregd;
    e_d.memwrite   = bus.memwrited;
    e_d.alusrc     = bus.alusrcd;
    e_d.regdst     = bus.regdstd;
    e_d.alucontrol = bus.alucontrold;
    e_d.rs         = bus.rsd;
    e_d.rt         = bus.rtd;
    e_d.rd         = bus.rdd;
  end

  // A stalled decode instruction is held upstream, so EX takes a bubble instead.
  ctrl_stage_reg #(.Width($bits(e_ctrl_t))) u_e_reg (
    .clk  (clk),
    .reset(reset),
    .clear(stall),
    .d    (e_d),
    .q    (e_q)
  );

  assign writerege = e_q.regdst ? e_q.rd : e_q.rt;

  always_comb begin
    m_d          = '0;
    m_d.regwrite = e_q.regwrite;
    m_d.memtoreg = e_q.memtoreg;
    m_d.memwrite = e_q.memwrite;
    m_d.writereg = writerege;
  end

  ctrl_stage_reg #(.Width($bits(m_ctrl_t))) u_m_reg (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .d    (m_d),
    .q    (m_q)
  );

  always_comb begin
    w_d          = '0;
    w_d.regwrite = m_q.regwrite;
    w_d.memtoreg = m_q.memtoreg;
    w_d.writereg = m_q.writereg;
  end

  ctrl_stage_reg #(.Width($bits(w_ctrl_t))) u_w_reg (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .d    (w_d),
    .q    (w_q)
  );

  always_comb begin
    lwstall = e_q.memtoreg && (e_q.rt != '0) && ((e_q.rt == bus.rsd) || (e_q.rt == bus.rtd));
`ifdef BRANCH_FWD_EN
    // ALU results in MEM are forwarded; only EX results and MEM loads must be waited out.
    branchstall = bus.branchd &&
                  ((e_q.regwrite && reg_hit(writerege, bus.rsd, bus.rtd)) ||
                   (m_q.memtoreg && reg_hit(m_q.writereg, bus.rsd, bus.rtd)));
    fwd_ad = (bus.rsd != '0) && m_q.regwrite && (m_q.writereg == bus.rsd);
    fwd_bd = (bus.rtd != '0) && m_q.regwrite && (m_q.writereg == bus.rtd);
`else
    branchstall = bus.branchd &&
                  ((e_q.regwrite && reg_hit(writerege, bus.rsd, bus.rtd)) ||
                   (m_q.regwrite && reg_hit(m_q.writereg, bus.rsd, bus.rtd)) ||
                   (w_q.regwrite && reg_hit(w_q.writereg, bus.rsd, bus.rtd)));
    fwd_ad = 1'b0;
    fwd_bd = 1'b0;
`endif
    stall = lwstall || branchstall;
  end

  always_ff @(posedge clk) begin
    if (reset)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.regwritee   = e_q.regwrite;
  assign bus.memtorege   = e_q.memtoreg;
  assign bus.memwritee   = e_q.memwrite;
  assign bus.alusrce     = e_q.alusrc;
  assign bus.alucontrole = e_q.alucontrol;
  assign bus.rse         = e_q.rs;
  assign bus.rte         = e_q.rt;
  assign bus.writerege   = writerege;
  assign bus.regwritem   = m_q.regwrite;
  assign bus.memtoregm   = m_q.memtoreg;
  assign bus.memwritem   = m_q.memwrite;
  assign bus.writeregm   = m_q.writereg;
  assign bus.regwritew   = w_q.regwrite;
  assign bus.memtoregw   = w_q.memtoreg;
  assign bus.writeregw   = w_q.writereg;

  assign bus.stallf    = stall;
  assign bus.stalld    = stall;
  assign bus.flushe    = stall;
  // Stall wins over a taken branch: the branch is re-evaluated once operands are ready.
  assign bus.flushd    = (|bus.pcsrcd) && !stall;
  assign bus.forwardae = fwd_sel(e_q.rs, m_q.regwrite, m_q.writereg, w_q.regwrite, w_q.writereg);
  assign bus.forwardbe = fwd_sel(e_q.rt, m_q.regwrite, m_q.writereg, w_q.regwrite, w_q.writereg);
  assign bus.forwardad = fwd_ad;
  assign bus.forwardbd = fwd_bd;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model of the E/M/W pipeline.
module tb_pipe_hazard_ctrl;
  import tiny_mips_pkg::*;

  localparam int unsigned CW      = 6;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: st[0]=EX, st[1]=MEM, st[2]=WB instruction records.
  typedef struct {
    bit       rw, mtr, mw, as;
    bit [2:0] alu;
    bit [4:0] rs, rt, wr;
  } ins_t;

  ins_t st[3];
  ins_t nop_i;
  int   raw_stalls = 0;
  bit   armed = 1'b0;

  function automatic bit hit(bit [4:0] wr, bit [4:0] a, bit [4:0] b);
    return (wr != 0) && ((wr == a) || (wr == b));
  endfunction

  function automatic bit m_stall();
    bit lw, bs;
    lw = st[0].mtr && hit(st[0].rt, bus.rsd, bus.rtd);
`ifdef BRANCH_FWD_EN
    bs = bus.branchd && ((st[0].rw && hit(st[0].wr, bus.rsd, bus.rtd)) ||
                         (st[1].mtr && hit(st[1].wr, bus.rsd, bus.rtd)));
`else
    bs = 1'b0;
    for (int k = 0; k < 3; k++)
      if (bus.branchd && st[k].rw && hit(st[k].wr, bus.rsd, bus.rtd)) bs = 1'b1;
`endif
    return lw || bs;
  endfunction

  function automatic bit [1:0] m_fwd(bit [4:0] src);
    if (src == 0) return 2'b00;
    if (st[1].rw && st[1].wr == src) return 2'b10;
    if (st[2].rw && st[2].wr == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_fwdd(bit [4:0] src);
`ifdef BRANCH_FWD_EN
    return (src != 0) && st[1].rw && (st[1].wr == src);
`else
    return (src != 0) && 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) st[k] = nop_i;
      raw_stalls = 0;
      armed = 1'b1;
    end else begin
      bit s;
      s = m_stall();
      if (s) raw_stalls++;
      st[2] = st[1];
      st[1] = st[0];
      if (s) st[0] = nop_i;
      else begin
        st[0].rw  = bus.regwrited;
        st[0].mtr = bus.memtoregd;
        st[0].mw  = bus.memwrited;
        st[0].as  = bus.alusrcd;
        st[0].alu = bus.alucontrold;
        st[0].rs  = bus.rsd;
        st[0].rt  = bus.rtd;
        st[0].wr  = bus.regdstd ? bus.rdd : bus.rtd;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      bit s;
      s = m_stall();
      chk("regwritee", 32'(bus.regwritee), 32'(st[0].rw));
      chk("memtorege", 32'(bus.memtorege), 32'(st[0].mtr));
      chk("memwritee", 32'(bus.memwritee), 32'(st[0].mw));
      chk("alusrce", 32'(bus.alusrce), 32'(st[0].as));
      chk("alucontrole", 32'(bus.alucontrole), 32'(st[0].alu));
      chk("rse", 32'(bus.rse), 32'(st[0].rs));
      chk("rte", 32'(bus.rte), 32'(st[0].rt));
      chk("writerege", 32'(bus.writerege), 32'(st[0].wr));
      chk("regwritem", 32'(bus.regwritem), 32'(st[1].rw));
      chk("memtoregm", 32'(bus.memtoregm), 32'(st[1].mtr));
      chk("memwritem", 32'(bus.memwritem), 32'(st[1].mw));
      chk("writeregm", 32'(bus.writeregm), 32'(st[1].wr));
      chk("regwritew", 32'(bus.regwritew), 32'(st[2].rw));
      chk("memtoregw", 32'(bus.memtoregw), 32'(st[2].mtr));
      chk("writeregw", 32'(bus.writeregw), 32'(st[2].wr));
      chk("stalld", 32'(bus.stalld), 32'(s));
      chk("stallf", 32'(bus.stallf), 32'(s));
      chk("flushe", 32'(bus.flushe), 32'(s));
      chk("flushd", 32'(bus.flushd), 32'((bus.pcsrcd != 0) && !s));
      chk("forwardae", 32'(bus.forwardae), 32'(m_fwd(bus.rse)));
      chk("forwardbe", 32'(bus.forwardbe), 32'(m_fwd(bus.rte)));
      chk("forwardad", 32'(bus.forwardad), 32'(m_fwdd(bus.rsd)));
      chk("forwardbd", 32'(bus.forwardbd), 32'(m_fwdd(bus.rtd)));
      chk("stall_cnt", 32'(stall_cnt),
          32'((raw_stalls > int'(CNT_MAX)) ? int'(CNT_MAX) : raw_stalls));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input bit rw, input bit mtr, input bit mw, input bit as, input bit rdst,
                      input bit br, input bit [2:0] alu, input bit [1:0] pc, input bit [4:0] rs,
                      input bit [4:0] rt, input bit [4:0] rd);
    bus.regwrited   = rw;
    bus.memtoregd   = mtr;
    bus.memwrited   = mw;
    bus.alusrcd     = as;
    bus.regdstd     = rdst;
    bus.branchd     = br;
    bus.alucontrold = alu;
    bus.pcsrcd      = pc;
    bus.rsd         = rs;
    bus.rtd         = rt;
    bus.rdd         = rd;
  endtask

  task automatic nop();                                  setd(0,0,0,0,0,0,3'd0,2'b00,0,0,0);  endtask
  task automatic alu_op(input bit [4:0] rd, rs, rt);     setd(1,0,0,0,1,0,3'd2,2'b00,rs,rt,rd); endtask
  task automatic lw(input bit [4:0] rt, rs);             setd(1,1,0,1,0,0,3'd2,2'b00,rs,rt,0); endtask
  task automatic beq(input bit [4:0] rs, rt);            setd(0,0,0,0,0,1,3'd6,2'b01,rs,rt,0); endtask
  task automatic jump();                                 setd(0,0,0,0,0,0,3'd0,2'b10,0,0,0);  endtask

  initial begin
    nop();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_regwritee", 32'(bus.regwritee), 32'd0);
    chk("rst_writeregw", 32'(bus.writeregw), 32'd0);
    chk("rst_forwardae", 32'(bus.forwardae), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use: lw $2 in EX, add reading $2 in decode.
    lw(2, 1); tick();
    alu_op(6, 2, 5); #1;
    chk("lu_stalld", 32'(bus.stalld), 32'd1);
    chk("lu_stallf", 32'(bus.stallf), 32'd1);
    chk("lu_flushe", 32'(bus.flushe), 32'd1);
    tick(); #1;
    chk("lu_bubble", 32'(bus.regwritee), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_released", 32'(bus.stalld), 32'd0);
    tick(); #1;
    chk("lu_fwd_wb", 32'(bus.forwardae), 32'b01);
    chk("lu_writerege", 32'(bus.writerege), 32'd6);

    // $3 in both MEM and WB: MEM wins.
    alu_op(3, 1, 1); tick();
    alu_op(3, 1, 1); tick();
    alu_op(7, 3, 0); tick(); #1;
    chk("fwd_both", 32'(bus.forwardae), 32'b10);
    chk("fwd_both_b", 32'(bus.forwardbe), 32'b00);
    // MEM only.
    nop(); tick();
    alu_op(3, 1, 1); tick();
    alu_op(7, 3, 0); tick(); #1;
    chk("fwd_mem", 32'(bus.forwardae), 32'b10);
    // WB only, both operands.
    alu_op(3, 1, 1); tick();
    nop(); tick();
    alu_op(7, 3, 3); tick(); #1;
    chk("fwd_wb_a", 32'(bus.forwardae), 32'b01);
    chk("fwd_wb_b", 32'(bus.forwardbe), 32'b01);

    // Writes to $0 never forward or stall.
    alu_op(0, 1, 1); tick();
    alu_op(0, 1, 1); tick();
    alu_op(7, 0, 0); tick(); #1;
    chk("r0_fwd", 32'(bus.forwardae), 32'b00);
    lw(0, 1); tick();
    alu_op(7, 0, 0); #1;
    chk("r0_nostall", 32'(bus.stalld), 32'd0);

    // Branch on $4 right behind the add that writes it.
    alu_op(4, 1, 1); tick();
    beq(4, 0); #1;
    chk("br_stall0", 32'(bus.stalld), 32'd1);
    chk("br_flushd0", 32'(bus.flushd), 32'd0);
    chk("br_fwdad0", 32'(bus.forwardad), 32'd0);
    tick(); #1;
`ifdef BRANCH_FWD_EN
    chk("br_fwd_go", 32'(bus.stalld), 32'd0);
    chk("br_fwdad", 32'(bus.forwardad), 32'd1);
    chk("br_flushd", 32'(bus.flushd), 32'd1);
    chk("br_cnt", 32'(stall_cnt), 32'd2);
`else
    chk("br_stall1", 32'(bus.stalld), 32'd1);
    chk("br_fwdad1", 32'(bus.forwardad), 32'd0);
    tick(); #1;
    chk("br_stall2", 32'(bus.stalld), 32'd1);
    tick(); #1;
    chk("br_go", 32'(bus.stalld), 32'd0);
    chk("br_fwdad3", 32'(bus.forwardad), 32'd0);
    chk("br_flushd", 32'(bus.flushd), 32'd1);
    chk("br_cnt", 32'(stall_cnt), 32'd4);
`endif

    // Load-use against a taken branch: stall wins, no decode flush.
    nop(); tick(); tick(); tick();
    lw(8, 1); tick();
    beq(8, 0); #1;
    chk("lwbr_stall", 32'(bus.stalld), 32'd1);
    chk("lwbr_flushd", 32'(bus.flushd), 32'd0);
    tick();

    // Jump with no hazard flushes decode in the same cycle.
    nop(); tick(); tick(); tick();
    jump(); #1;
    chk("jmp_flushd", 32'(bus.flushd), 32'd1);
    chk("jmp_stalld", 32'(bus.stalld), 32'd0);
    tick();

    // Reset mid-stream.
    alu_op(9, 1, 1); tick();
    lw(10, 1); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("mrst_regwritee", 32'(bus.regwritee), 32'd0);
    chk("mrst_memtorege", 32'(bus.memtorege), 32'd0);
    chk("mrst_regwritem", 32'(bus.regwritem), 32'd0);
    chk("mrst_writeregm", 32'(bus.writeregm), 32'd0);
    chk("mrst_regwritew", 32'(bus.regwritew), 32'd0);
    chk("mrst_writeregw", 32'(bus.writeregw), 32'd0);
    chk("mrst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Drive the stall counter past full scale.
    for (int r = 0; r < 200; r++) begin
      if (raw_stalls >= int'(CNT_MAX) + 5) break;
      alu_op(4, 1, 1); tick();
      beq(4, 0);
      tick(); tick(); tick(); tick();
    end
    nop(); #1;
    chk("sat_reached", 32'(raw_stalls >= int'(CNT_MAX) + 5), 32'd1);
    chk("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    tick(); #1;
    chk("sat_hold", 32'(stall_cnt), 32'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
